// File: rtl/pid_seq_pkg.sv
// Shared types and default constants for the forward-speed sequencer.
// Also holds the |err| helper used by the settle detector.
package pid_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RAMP   = 3'd1,
    RUN    = 3'd2,
    DECEL  = 3'd3,
    SETTLE = 3'd4
  } state_t;

  localparam logic [9:0] DEF_MAX_FRWRD     = 10'd512;
  localparam logic [9:0] DEF_RAMP_STEP     = 10'd16;
  localparam logic [9:0] DEF_SETTLE_THRESH = 10'd16;
  localparam logic [7:0] DEF_SETTLE_CNT    = 8'd8;

  // Widened to 11 bits so that -512 maps to +512 instead of wrapping.
  function automatic logic [10:0] abs_err(input logic signed [9:0] v);
    logic signed [10:0] ext;
    ext = {v[9], v};
    if (ext[10])
      return 11'(-ext);
    else
      return 11'(ext);
  endfunction

endpackage

// File: rtl/err_sat_12to10.sv
// Clamps a signed 12-bit heading error into the signed 10-bit PID range.
module err_sat_12to10 (
  input  logic signed [11:0] error,
  output logic signed [9:0]  err_sat
);

  always_comb begin
    err_sat = error[9:0];
    if (error > 12'sd511)
      err_sat = 10'sh1FF;
    else if (error < -12'sd512)
      err_sat = 10'sh200;
  end

endmodule

// File: rtl/pid_seq.sv
// Forward-speed sequencer: ramps frwrd up on go, down on stop, then waits for
// the heading error to settle before pulsing done.
//
//   state  | meaning
//   IDLE   | stopped, frwrd = 0, integrator cleared
//   RAMP   | frwrd rises by RAMP_STEP per sample up to MAX_FRWRD
//   RUN    | cruising at MAX_FRWRD
//   DECEL  | frwrd falls by RAMP_STEP per sample down to 0
//   SETTLE | frwrd = 0, counting consecutive small-error samples
module pid_seq
  import pid_seq_pkg::*;
#(
  parameter logic [9:0] MAX_FRWRD     = DEF_MAX_FRWRD,
  parameter logic [9:0] RAMP_STEP     = DEF_RAMP_STEP,
  parameter logic [9:0] SETTLE_THRESH = DEF_SETTLE_THRESH,
  parameter logic [7:0] SETTLE_CNT    = DEF_SETTLE_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              stop,
  input  logic signed [11:0] error,
  input  logic              error_vld,
  output logic signed [9:0] err_sat,
  output logic              err_vld,
  output logic              moving,
  output logic [9:0]        frwrd,
  output logic              done
);

  state_t      state_q, state_d;
  logic [9:0]  frwrd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_d;
  logic signed [9:0] err_sat_c;
  logic [10:0] ramp_sum;
  logic [7:0]  cnt_inc;
  logic        settled;

  err_sat_12to10 u_sat (
    .error   (error),
    .err_sat (err_sat_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sat <= '0;
      err_vld <= 1'b0;
    end else begin
      err_vld <= error_vld;
      if (error_vld)
        err_sat <= err_sat_c;
    end
  end

  assign ramp_sum = {1'b0, frwrd} + {1'b0, RAMP_STEP};
  assign cnt_inc  = cnt_q + 8'd1;
  assign settled  = (abs_err(err_sat) <= {1'b0, SETTLE_THRESH});

  always_comb begin
    state_d = state_q;
    frwrd_d = frwrd;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        frwrd_d = '0;
        cnt_d   = '0;
        if (go && !stop)
          state_d = RAMP;
      end
      RAMP: begin
        // stop wins over a coincident sample so frwrd freezes where it is
        if (stop) begin
          state_d = DECEL;
        end else if (err_vld) begin
          if (ramp_sum >= {1'b0, MAX_FRWRD}) begin
            frwrd_d = MAX_FRWRD;
            state_d = RUN;
          end else begin
            frwrd_d = ramp_sum[9:0];
          end
        end
      end
      RUN: begin
        frwrd_d = MAX_FRWRD;
        if (stop)
          state_d = DECEL;
      end
      DECEL: begin
        if (err_vld) begin
          if (frwrd <= RAMP_STEP) begin
            frwrd_d = '0;
            cnt_d   = '0;
            state_d = SETTLE;
          end else begin
            frwrd_d = frwrd - RAMP_STEP;
          end
        end
      end
      SETTLE: begin
        frwrd_d = '0;
        if (err_vld) begin
          if (settled) begin
            if (cnt_inc == SETTLE_CNT) begin
              cnt_d   = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        frwrd_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frwrd   <= '0;
      cnt_q   <= '0;
      done    <= 1'b0;
      moving  <= 1'b0;
    end else begin
      state_q <= state_d;
      frwrd   <= frwrd_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
      moving  <= (state_d != IDLE);
    end
  end

endmodule
